// File: rtl/axis_sum_pkg.sv
//------------------------------------------------------------------------------
// Module : axis_sum_pkg
// Brief  : Shared types and helpers for the N-channel complex beam-sum block.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axis_sum_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'd0,
    MODE_SAT   = 2'd1,
    MODE_SCALE = 2'd2
  } mode_e;

  localparam mode_e MODE_RESERVED_MAP = MODE_SAT;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                 input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_sum_lane.sv
//------------------------------------------------------------------------------
// Module : axis_sum_lane
// Brief  : One sample lane: masked sign-extended channel sum and mode conversion.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_sum_lane
  import axis_sum_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GROWTH       = 2,
  parameter int SUM_WIDTH    = SAMPLE_WIDTH + GROWTH
) (
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] i_samples,
  input  logic [NUM_CH-1:0]              i_en,
  output logic signed [SUM_WIDTH-1:0]    o_sum,
  input  logic signed [SUM_WIDTH-1:0]    i_sum,
  input  mode_e                          i_mode,
  output logic [SAMPLE_WIDTH-1:0]        o_out,
  output logic                           o_sat
);

  logic signed [SUM_WIDTH-1:0]    w_acc;
  logic        [SAMPLE_WIDTH-1:0] w_smp;
  logic signed [63:0]             w_wide;
  logic signed [63:0]             w_scaled;
  logic signed [63:0]             w_pre;
  logic signed [63:0]             w_clamped;

  always_comb begin
    w_acc = '0;
    w_smp = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_smp = i_samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (i_en[c]) w_acc = w_acc + {{GROWTH{w_smp[SAMPLE_WIDTH-1]}}, w_smp};
    end
  end

  assign o_sum = w_acc;

  // Round-half-up before the arithmetic shift gives floor(sum/N + 0.5).
  assign w_wide    = {{(64-SUM_WIDTH){i_sum[SUM_WIDTH-1]}}, i_sum};
  assign w_scaled  = (w_wide + (64'sd1 <<< (GROWTH - 1))) >>> GROWTH;
  assign w_pre     = (i_mode == MODE_SCALE) ? w_scaled : w_wide;
  assign w_clamped = saturate(w_pre, SAMPLE_WIDTH);

  always_comb begin
    o_out = w_clamped[SAMPLE_WIDTH-1:0];
    o_sat = (w_clamped != w_pre);
    if (i_mode == MODE_WRAP) begin
      o_out = i_sum[SAMPLE_WIDTH-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_complex_sum_n.sv
//------------------------------------------------------------------------------
// Module : axis_complex_sum_n
// Brief  : N-channel complex AXIS beam sum with join, 2-stage pipe and status.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_complex_sum_n
  import axis_sum_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES      = 8,
  parameter int HALF_WIDTH   = SAMPLE_WIDTH * SAMPLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   cfg_mode,
  input  logic [NUM_CH-1:0]            cfg_ch_en,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH*2*HALF_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [2*HALF_WIDTH-1:0]      m_axis_tdata,
  output logic [2*HALF_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [31:0]                  sat_count,
  output logic [31:0]                  pkt_count,
  output logic                         err_tlast_mismatch
);

  localparam int GROWTH    = clog2(NUM_CH);
  localparam int SUM_WIDTH = SAMPLE_WIDTH + GROWTH;
  localparam int LANES     = 2 * SAMPLES;
  localparam int CH_W      = 2 * HALF_WIDTH;

  logic                               r_open;
  logic [NUM_CH-1:0]                  r_en;
  mode_e                              r_mode;
  logic                               r_v1;
  logic [LANES-1:0][SUM_WIDTH-1:0]    r_sum1;
  mode_e                              r_mode1;
  logic                               r_last1;
  logic                               r_v2;
  logic [2*HALF_WIDTH-1:0]            r_data2;
  logic                               r_last2;
  logic [31:0]                        r_sat_count;
  logic [31:0]                        r_pkt_count;
  logic                               r_err;

  logic [NUM_CH-1:0]                  w_en;
  mode_e                              w_mode_live;
  mode_e                              w_mode;
  logic                               w_all_valid;
  logic                               w_drain2;
  logic                               w_adv1;
  logic                               w_s1_free;
  logic                               w_accept;
  logic                               w_last;
  logic                               w_found;
  logic                               w_mismatch;
  logic [LANES-1:0][SUM_WIDTH-1:0]    w_sum;
  logic [2*HALF_WIDTH-1:0]            w_out;
  logic [LANES-1:0]                   w_sat;
  logic [31:0]                        w_sat_n;
  logic [32:0]                        w_sat_next;

  // Between packets the live config drives the join; it is frozen on accept.
  assign w_mode_live = (cfg_mode == 2'd3) ? MODE_RESERVED_MAP : mode_e'(cfg_mode);
  assign w_en        = r_open ? r_en   : cfg_ch_en;
  assign w_mode      = r_open ? r_mode : w_mode_live;

  assign w_all_valid = (&(s_axis_tvalid | ~w_en)) && (w_en != '0);
  assign w_drain2    = r_v2 & m_axis_tready;
  assign w_adv1      = r_v1 & (~r_v2 | w_drain2);
  assign w_s1_free   = ~r_v1 | w_adv1;
  assign w_accept    = w_all_valid & w_s1_free & ~reset;

  assign s_axis_tready = {NUM_CH{w_accept}} & w_en;

  always_comb begin
    w_last     = 1'b0;
    w_found    = 1'b0;
    w_mismatch = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_en[c]) begin
        if (!w_found) begin
          w_last  = s_axis_tlast[c];
          w_found = 1'b1;
        end else if (s_axis_tlast[c] != w_last) begin
          w_mismatch = 1'b1;
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int OFS = (l < SAMPLES) ? l * SAMPLE_WIDTH
                                       : HALF_WIDTH + (l - SAMPLES) * SAMPLE_WIDTH;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] w_in;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_tdata[c*CH_W + OFS +: SAMPLE_WIDTH];
    end

    axis_sum_lane #(
      .NUM_CH       (NUM_CH),
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .GROWTH       (GROWTH),
      .SUM_WIDTH    (SUM_WIDTH)
    ) u_lane (
      .i_samples (w_in),
      .i_en      (w_en),
      .o_sum     (w_sum[l]),
      .i_sum     (r_sum1[l]),
      .i_mode    (r_mode1),
      .o_out     (w_out[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .o_sat     (w_sat[l])
    );
  end

  always_comb begin
    w_sat_n = '0;
    for (int l = 0; l < LANES; l++) w_sat_n = w_sat_n + {31'd0, w_sat[l]};
  end

  assign w_sat_next = {1'b0, r_sat_count} + {1'b0, w_sat_n};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_open      <= 1'b0;
      r_en        <= '1;
      r_mode      <= MODE_SAT;
      r_v1        <= 1'b0;
      r_sum1      <= '0;
      r_mode1     <= MODE_SAT;
      r_last1     <= 1'b0;
      r_v2        <= 1'b0;
      r_data2     <= '0;
      r_last2     <= 1'b0;
      r_sat_count <= '0;
      r_pkt_count <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_open <= ~w_last;
        if (!r_open) begin
          r_en   <= cfg_ch_en;
          r_mode <= w_mode_live;
        end
        if (w_mismatch) r_err <= 1'b1;
      end else if (!r_open && cfg_ch_en == '0) begin
        // An empty mask opens a packet that can never close: stall until reset.
        r_open <= 1'b1;
        r_en   <= '0;
        r_mode <= w_mode_live;
      end

      if (w_accept) begin
        r_v1    <= 1'b1;
        r_sum1  <= w_sum;
        r_mode1 <= w_mode;
        r_last1 <= w_last;
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end

      if (w_adv1) begin
        r_v2        <= 1'b1;
        r_data2     <= w_out;
        r_last2     <= r_last1;
        r_sat_count <= w_sat_next[32] ? '1 : w_sat_next[31:0];
      end else if (w_drain2) begin
        r_v2 <= 1'b0;
      end

      if (w_drain2 && r_last2) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign m_axis_tvalid      = r_v2;
  assign m_axis_tdata       = r_data2;
  assign m_axis_tkeep       = {(2*HALF_WIDTH/8){r_v2}};
  assign m_axis_tlast       = r_last2;
  assign sat_count          = r_sat_count;
  assign pkt_count          = r_pkt_count;
  assign err_tlast_mismatch = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_complex_sum_n.sv
//------------------------------------------------------------------------------
// Module : tb_axis_complex_sum_n
// Brief  : Directed bench with an integer-arithmetic scoreboard for the beam sum.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_complex_sum_n;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int S   = 8;
  localparam int H   = W * S;
  localparam int CHW = 2 * H;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           cfg_mode;
  logic [NCH-1:0]       cfg_ch_en;
  logic [NCH-1:0]       s_tvalid;
  logic [NCH-1:0]       s_tready;
  logic [NCH*CHW-1:0]   s_tdata;
  logic [NCH-1:0]       s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [CHW-1:0]       m_tdata;
  logic [CHW/8-1:0]     m_tkeep;
  logic                 m_tlast;
  logic [31:0]          sat_count;
  logic [31:0]          pkt_count;
  logic                 err_flag;

  always #5 clock = ~clock;

  axis_complex_sum_n #(
    .NUM_CH(NCH), .SAMPLE_WIDTH(W), .SAMPLES(S)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cfg_mode           (cfg_mode),
    .cfg_ch_en          (cfg_ch_en),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tready      (s_tready),
    .s_axis_tdata       (s_tdata),
    .s_axis_tlast       (s_tlast),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tkeep       (m_tkeep),
    .m_axis_tlast       (m_tlast),
    .sat_count          (sat_count),
    .pkt_count          (pkt_count),
    .err_tlast_mismatch (err_flag)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected beats derived from handshaked inputs by plain integer sums.
  typedef struct { logic [CHW-1:0] data; bit last; } beat_t;
  beat_t          q[$];
  bit             m_open;
  logic [NCH-1:0] m_en;
  int             m_mode;
  int             exp_sat;
  int             exp_pkt;
  bit             exp_err;
  bit             prev_stall;
  logic [CHW-1:0] prev_data;
  bit             prev_last;

  function automatic void conv(input int sum, input int mode, output int o, output bit sat);
    int t;
    sat = 0;
    o   = sum;
    if (mode != 0) begin
      t = (mode == 2) ? ((sum + 2) >>> 2) : sum;
      if (t > 32767)       begin o = 32767;  sat = 1; end
      else if (t < -32768) begin o = -32768; sat = 1; end
      else                 o = t;
    end
  endfunction

  always @(negedge clock) begin
    beat_t          e;
    logic [NCH-1:0] en;
    int             mode, sum, base, o;
    bit             sat, found, lst;
    logic signed [15:0] v;
    if (reset) begin
      q.delete();
      m_open = 0; exp_sat = 0; exp_pkt = 0; exp_err = 0; prev_stall = 0;
    end else begin
      if (m_tvalid) begin
        if (prev_stall) begin
          check("hold_data", m_tdata, prev_data);
          check("hold_last", m_tlast, prev_last);
        end
        check("tkeep", m_tkeep, 32'hFFFF_FFFF);
        if (m_tready) begin
          if (q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL out_extra: got beat %0h expected no beat", m_tdata);
          end else begin
            e = q.pop_front();
            check("out_data", m_tdata, e.data);
            check("out_last", m_tlast, e.last);
            if (e.last) exp_pkt++;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;

      if (s_tready != '0) begin
        en   = m_open ? m_en : cfg_ch_en;
        mode = m_open ? m_mode : ((cfg_mode == 2'd3) ? 1 : int'(cfg_mode));
        check("tready_mask", s_tready, en);
        check("join_valid", s_tvalid & en, en);
        if (!m_open) begin m_en = en; m_mode = mode; end
        for (int l = 0; l < 2*S; l++) begin
          sum  = 0;
          base = (l < S) ? l*W : H + (l-S)*W;
          for (int c = 0; c < NCH; c++) begin
            v = s_tdata[c*CHW + base +: W];
            if (en[c]) sum += int'(v);
          end
          conv(sum, mode, o, sat);
          e.data[l*W +: W] = o[15:0];
          if (sat) exp_sat++;
        end
        found = 0; lst = 0;
        for (int c = 0; c < NCH; c++) begin
          if (en[c]) begin
            if (!found) begin lst = s_tlast[c]; found = 1; end
            else if (s_tlast[c] != lst) exp_err = 1;
          end
        end
        e.last = lst;
        m_open = !lst;
        q.push_back(e);
      end
    end
  end

  function automatic logic [NCH*CHW-1:0] fill(input logic [15:0] re, input logic [15:0] im);
    logic [NCH*CHW-1:0] d;
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < S; l++) begin
        d[c*CHW + l*W +: W]     = re;
        d[c*CHW + H + l*W +: W] = im;
      end
    return d;
  endfunction

  function automatic logic [NCH*CHW-1:0] burst_beat(input int b);
    logic [NCH*CHW-1:0] d;
    int t;
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < 2*S; l++) begin
        t = (b*37 + c*1000 + l*53) * 97;
        d[c*CHW + l*W +: W] = t[15:0];
      end
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [NCH*CHW-1:0] data, input logic [NCH-1:0] valid,
                      input logic [NCH-1:0] last);
    int n;
    s_tdata = data; s_tvalid = valid; s_tlast = last;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (s_tready != '0) break;
      n++;
      if (n > 200) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout: ready %b expected nonzero", s_tready);
        break;
      end
    end
    @(posedge clock); #1;
    s_tvalid = '0;
  endtask

  task automatic xfer(input logic [NCH*CHW-1:0] data, input logic [NCH-1:0] valid,
                      input logic [NCH-1:0] last, output logic [CHW-1:0] out,
                      output logic out_last, output int lat);
    send(data, valid, last);
    lat = 0; out = '0; out_last = 0;
    while (lat < 50) begin
      @(negedge clock);
      lat++;
      if (m_tvalid) begin out = m_tdata; out_last = m_tlast; break; end
    end
    if (!m_tvalid) begin
      n_checks++; n_errors++;
      $display("FAIL xfer_timeout: tvalid %b expected 1", m_tvalid);
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 || m_tvalid) begin
      @(negedge clock);
      n++;
      if (n > 300) begin
        n_checks++; n_errors++;
        $display("FAIL idle_timeout: pending %0d expected 0", q.size());
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic checkpoint(input string tag);
    wait_idle();
    check({tag, "_sat"}, sat_count, exp_sat);
    check({tag, "_pkt"}, pkt_count, exp_pkt);
    check({tag, "_err"}, err_flag, exp_err);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [CHW-1:0] out;
    logic           olast;
    int             lat;

    reset = 1'b1; cfg_mode = 2'd1; cfg_ch_en = 4'hF;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tready", s_tready, 0);
    check("rst_counts", {sat_count, pkt_count}, 0);
    check("rst_err", err_flag, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic sum and latency
    cfg_mode = 2'd0;
    xfer(fill(16'h1000, 16'hFFFF), 4'hF, 4'hF, out, olast, lat);
    check("wrap_basic", out, {{8{16'hFFFC}}, {8{16'h4000}}});
    check("latency", lat, 2);

    cfg_mode = 2'd1;
    xfer(fill(16'h7FFF, 16'h7FFF), 4'hF, 4'hF, out, olast, lat);
    check("sat_max", out, {16{16'h7FFF}});
    checkpoint("after_sat");
    check("sat_cnt16", sat_count, 16);

    cfg_mode = 2'd0;
    xfer(fill(16'h7FFF, 16'h7FFF), 4'hF, 4'hF, out, olast, lat);
    check("wrap_max", out, {16{16'hFFFC}});

    cfg_mode = 2'd2;
    xfer(fill(16'h7FFF, 16'h7FFF), 4'hF, 4'hF, out, olast, lat);
    check("scale_max", out, {16{16'h7FFF}});
    xfer(fill(16'h8000, 16'h8000), 4'hF, 4'hF, out, olast, lat);
    check("scale_min", out, {16{16'h8000}});

    cfg_mode = 2'd3;
    xfer(fill(16'h8000, 16'h8000), 4'hF, 4'hF, out, olast, lat);
    check("reserved_sat", out, {16{16'h8000}});
    checkpoint("modes");
    check("sat_cnt32", sat_count, 32);
    check("pkt_cnt6", pkt_count, 6);

    // 64-beat burst with a mid-burst output stall
    cfg_mode = 2'd1;
    fork
      begin
        for (int b = 0; b < 64; b++)
          send(burst_beat(b), 4'hF, (b == 63) ? 4'hF : 4'h0);
      end
      begin
        repeat (20) @(posedge clock);
        #1 m_tready = 1'b0;
        repeat (5) @(negedge clock);
        check("stall_tready", s_tready, 0);
        check("stall_buffered", q.size(), 2);
        repeat (5) @(posedge clock);
        #1 m_tready = 1'b1;
      end
    join
    checkpoint("burst");
    check("pkt_cnt7", pkt_count, 7);

    // Partial mask; mask change inside a packet is deferred
    cfg_mode = 2'd0; cfg_ch_en = 4'b1011;
    xfer(fill(16'h0100, 16'h0100), 4'b1011, 4'b0000, out, olast, lat);
    check("mask_sum", out, {16{16'h0300}});
    cfg_ch_en = 4'b0001;
    xfer(fill(16'h0100, 16'h0100), 4'b1011, 4'b1011, out, olast, lat);
    check("mask_held", out, {16{16'h0300}});
    xfer(fill(16'h0100, 16'h0100), 4'hF, 4'b0001, out, olast, lat);
    check("mask_new", out, {16{16'h0100}});
    checkpoint("mask");
    check("pkt_cnt9", pkt_count, 9);

    // tlast disagreement
    cfg_ch_en = 4'hF;
    xfer(fill(16'h0001, 16'h0002), 4'hF, 4'b0001, out, olast, lat);
    check("mism_data", out, {{8{16'h0008}}, {8{16'h0004}}});
    check("mism_last", olast, 1);
    checkpoint("mism");
    check("mism_flag", err_flag, 1);
    check("pkt_cnt10", pkt_count, 10);
    xfer(fill(16'h0002, 16'h0002), 4'hF, 4'hF, out, olast, lat);
    checkpoint("sticky");
    check("err_sticky", err_flag, 1);

    // Reset with two beats in flight
    m_tready = 1'b0; cfg_mode = 2'd1;
    send(fill(16'h0111, 16'h0222), 4'hF, 4'h0);
    send(fill(16'h0333, 16'h0444), 4'hF, 4'h0);
    pulse_reset();
    @(negedge clock);
    check("rstf_tvalid", m_tvalid, 0);
    check("rstf_counts", {sat_count, pkt_count}, 0);
    check("rstf_err", err_flag, 0);
    @(posedge clock); #1;
    m_tready = 1'b1;
    xfer(fill(16'h0123, 16'hFEDC), 4'hF, 4'hF, out, olast, lat);
    check("post_rst", out, {{8{16'hFB70}}, {8{16'h048C}}});
    checkpoint("post_rst");

    // Empty mask stalls until reset
    cfg_ch_en = 4'h0; s_tdata = fill(16'h0001, 16'h0001); s_tvalid = 4'hF; s_tlast = 4'hF;
    repeat (5) @(negedge clock);
    check("zero_tready", s_tready, 0);
    cfg_ch_en = 4'hF;
    repeat (3) @(negedge clock);
    check("zero_stuck", s_tready, 0);
    check("zero_noout", m_tvalid, 0);
    @(posedge clock); #1;
    s_tvalid = '0;
    pulse_reset();
    cfg_mode = 2'd0;
    xfer(fill(16'h0010, 16'h0020), 4'hF, 4'hF, out, olast, lat);
    check("zero_recover", out, {{8{16'h0080}}, {8{16'h0040}}});
    checkpoint("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
